// File: rtl/display_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_pkg: segment type, blank pattern and hex decode table    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hex_to_7seg: combinational nibble to active-low segment decoder  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nib_i);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seven_seg_scan_driver: multiplexed N-digit hex display driver    |
// | with frame-aligned value commit and leading-zero blanking.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module seven_seg_scan_driver
    import display_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned REFRESH_HZ  = 1_000,
    parameter int unsigned N_DIGITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  value_valid,
    output logic                  value_ack,
    input  logic                  blank_zeros,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned TICK_MAX = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W    = $clog2(TICK_MAX);
    localparam int unsigned IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VAL_W    = 4 * N_DIGITS;

    logic [CNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VAL_W-1:0]    staging_q, staging_d;
    logic [VAL_W-1:0]    shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic                ack_q, ack_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    seg_t                seg_q;
    logic                dp_q, dp_d;

    logic                tick;
    logic                frame_end;
    logic [3:0]          nib;
    logic                upper_zero;
    logic                blank;
    seg_t                nib_seg;

    hex_to_7seg u_dec (
        .nib_i (nib),
        .seg_o (nib_seg)
    );

    always_comb begin
        tick      = (count_q == CNT_W'(TICK_MAX - 1));
        frame_end = tick && (idx_q == IDX_W'(N_DIGITS - 1));
        count_d   = tick ? '0 : count_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        staging_d = staging_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        ack_d     = 1'b0;
        if (value_valid) begin
            staging_d = value_in;
            pending_d = 1'b1;
        end
        // A valid landing on the frame end bypasses staging straight to the shadow
        if (frame_end && (pending_q || value_valid)) begin
            shadow_d  = value_valid ? value_in : staging_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end

        nib        = 4'h0;
        upper_zero = 1'b1;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib = shadow_q[4*k +: 4];
            end
            if ((IDX_W'(k) >= idx_q) && (shadow_q[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        blank = blank_zeros && (idx_q != '0) && upper_zero;

        an_d = '1;
        if (!blank) begin
            an_d[idx_q] = 1'b0;
        end
        dp_d = ~dp_in[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            idx_q     <= '0;
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            count_q   <= count_d;
            idx_q     <= idx_d;
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            an_q      <= an_d;
            seg_q     <= nib_seg;
            dp_q      <= dp_d;
        end
    end

    assign value_ack = ack_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;

endmodule
`default_nettype wire
